// File: rtl/compressor_stream_arbiter.sv
// -----------------------------------------------------------------------------
// compressor_stream_arbiter
// Packet-granular round-robin arbiter sharing the compressor ingress stream
// between NUM_SRC AXI-Stream sources. The grant is held for a whole packet so
// downstream header logic never sees interleaved beats. Packets longer than
// MAX_BEATS are force-terminated and flagged in a sticky error bit.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   s_tdata/tvalid/tlast source beats (source i at [i*DATA_WIDTH +: DATA_WIDTH])
//   s_tready             per-source ready (only the granted source sees m_tready)
//   m_tdata/tvalid/tlast stream to the compressor
//   m_tready             compressor ready (!full_infifo)
//   m_tid                index of the granted source
//   busy                 a grant is held
//   pkt_count            packets forwarded (accepted m_tlast beats), wraps
//   err_trunc            sticky: a packet was force-terminated
//   err_clr              clears err_trunc (a same-cycle set wins)
// -----------------------------------------------------------------------------
module compressor_stream_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned MAX_BEATS  = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [ID_WIDTH-1:0]           m_tid,
    output logic                          busy,
    output logic [15:0]                   pkt_count,
    output logic                          err_trunc,
    input  logic                          err_clr
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS);
    localparam int unsigned PKT_W = 16;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_WIDTH-1:0] LAST_SRC = ID_WIDTH'(NUM_SRC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [PKT_W-1:0]    pkt_count_q, pkt_count_d;
    logic                err_trunc_q, err_trunc_d;

    logic                arb_valid;
    logic [ID_WIDTH-1:0] arb_pick;
    int unsigned         lg;
    int unsigned         rank;
    int unsigned         best_rank;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  cnt_full;

    assign busy      = (state_q == BUSY);
    assign pkt_count = pkt_count_q;
    assign err_trunc = err_trunc_q;

    // Round-robin pick: rank 0 is the source just after last_grant.
    always_comb begin
        arb_valid = 1'b0;
        arb_pick  = '0;
        best_rank = NUM_SRC;
        rank      = 0;
        lg        = 32'(last_grant_q);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rank = (i + NUM_SRC - 1 - lg) % NUM_SRC;
            if (s_tvalid[i] && (rank < best_rank)) begin
                best_rank = rank;
                arb_pick  = ID_WIDTH'(i);
                arb_valid = 1'b1;
            end
        end
    end

    // Granted-source mux.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Next-state and stream outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_count_d  = pkt_count_q;
        err_trunc_d  = err_clr ? 1'b0 : err_trunc_q;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tid        = '0;
        s_tready     = '0;
        cnt_full     = (beat_cnt_q == LAST_CNT);

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d    = arb_pick;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                m_tdata  = sel_data;
                m_tvalid = sel_valid;
                m_tlast  = sel_last | cnt_full;
                m_tid    = grant_q;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    s_tready[i] = (grant_q == ID_WIDTH'(i)) & m_tready;
                end
                if (sel_valid && m_tready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (m_tlast) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        pkt_count_d  = pkt_count_q + PKT_W'(1);
                        state_d      = IDLE;
                        // Length limit reached without source tlast: set beats clear.
                        if (cnt_full && !sel_last) begin
                            err_trunc_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_SRC;
            beat_cnt_q   <= '0;
            pkt_count_q  <= '0;
            err_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_count_q  <= pkt_count_d;
            err_trunc_q  <= err_trunc_d;
        end
    end

endmodule

// File: tb/tb_compressor_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_compressor_stream_arbiter
// Scoreboard bench: packets are loaded into per-source queues, a packet-level
// model (split at tlast or MAX_BEATS, serve one segment per source in
// round-robin order) pushes the expected output beats, and a negedge monitor
// pops and compares every accepted beat and every stalled beat.
// -----------------------------------------------------------------------------
module tb_compressor_stream_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tlast;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic [IW-1:0]    m_tid;
    logic             busy;
    logic [15:0]      pkt_count;
    logic             err_trunc;
    logic             err_clr;

    compressor_stream_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .m_tid(m_tid), .busy(busy), .pkt_count(pkt_count),
        .err_trunc(err_trunc), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    int    seg_len [NS][$];
    int    gap [NS];
    int    seg_pos [NS];
    int    taken [NS];
    int    rdy_sched [$];
    int    rdy_pct;
    bit    gap_en;
    bit    clr_force;
    int    clr_at;
    int    mdl_last;
    int    exp_pkts;
    bit    exp_trunc;
    bit    mon_en;
    int    beats_seen;
    int    chk_main, fail_main;
    int    chk_mon, fail_mon;
    beat_t mon_e;
    logic [NS-1:0] mon_oh;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (m_tvalid && m_tready) begin
                chk_mon++;
                if (exp_q.size() == 0) begin
                    fail_mon++;
                    $display("FAIL unexpected_beat tid=%0d data=%h", m_tid, m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.id] = 1'b1;
                    beats_seen++;
                    if (m_tdata !== mon_e.data || m_tlast !== mon_e.last ||
                        m_tid !== mon_e.id || s_tready !== mon_oh) begin
                        fail_mon++;
                        $display("FAIL beat got data=%h last=%b tid=%0d rdy=%b exp data=%h last=%b tid=%0d rdy=%b",
                                 m_tdata, m_tlast, m_tid, s_tready, mon_e.data, mon_e.last, mon_e.id, mon_oh);
                    end
                end
            end else if (m_tvalid && exp_q.size() > 0) begin
                chk_mon++;
                if (m_tdata !== exp_q[0].data || m_tid !== exp_q[0].id || s_tready !== '0) begin
                    fail_mon++;
                    $display("FAIL stall_hold got data=%h tid=%0d rdy=%b exp data=%h tid=%0d rdy=0",
                             m_tdata, m_tid, s_tready, exp_q[0].data, exp_q[0].id);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_main++;
        if (got !== exp) begin
            fail_main++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = $urandom;
            x.last = (b == len - 1);
            x.id   = IW'(s);
            src_q[s].push_back(x);
        end
    endtask

    // Packet-level reference: segment each source's stream, then serve one
    // segment per pending source in round-robin order after the last served.
    task automatic issue();
        int n, s, len;
        int pos [NS];
        bit any;
        beat_t e;
        for (int i = 0; i < NS; i++) begin
            seg_len[i].delete();
            pos[i] = 0;
            n = 0;
            foreach (src_q[i][j]) begin
                n++;
                if (src_q[i][j].last || n == MAXB) begin
                    seg_len[i].push_back(n);
                    if (!src_q[i][j].last) exp_trunc = 1'b1;
                    n = 0;
                end
            end
        end
        do begin
            any = 1'b0;
            for (int k = 1; k <= NS; k++) begin
                s = (mdl_last + k) % NS;
                if (!any && seg_len[s].size() > 0) begin
                    len = seg_len[s].pop_front();
                    for (int b = 0; b < len; b++) begin
                        e = src_q[s][pos[s] + b];
                        e.id = IW'(s);
                        e.last = (b == len - 1);
                        exp_q.push_back(e);
                    end
                    pos[s] += len;
                    mdl_last = s;
                    exp_pkts++;
                    any = 1'b1;
                end
            end
        end while (any);
    endtask

    // One clock of source/sink driving.
    task automatic cycle();
        logic [NS-1:0] hs;
        beat_t b;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                b = src_q[i].pop_front();
                taken[i]++;
                seg_pos[i]++;
                if (b.last || seg_pos[i] == MAXB) seg_pos[i] = 0;
                else if (gap_en && $urandom_range(0, 2) == 0) gap[i] = $urandom_range(1, 2);
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (gap[i] > 0) begin
                s_tvalid[i] = 1'b0;
                gap[i]--;
            end else if (src_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tlast[i] = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        if (rdy_sched.size() > 0) m_tready = (rdy_sched.pop_front() != 0);
        else m_tready = ($urandom_range(0, 99) < rdy_pct);
        err_clr = clr_force || (clr_at >= 0 && taken[0] == clr_at);
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        cycle();
        cycle();
        chk({name, "_pkt_count"}, 64'(pkt_count), 64'(16'(exp_pkts)));
        chk({name, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_clr();
        clr_force = 1'b1;
        cycle();
        clr_force = 1'b0;
        cycle();
        exp_trunc = 1'b0;
        chk("err_clr_alone", 64'(err_trunc), 64'd0);
    endtask

    task automatic clear_bench();
        exp_q.delete();
        rdy_sched.delete();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            gap[i] = 0;
            seg_pos[i] = 0;
            taken[i] = 0;
        end
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        mdl_last = NS - 1;
        exp_pkts = 0;
        exp_trunc = 1'b0;
    endtask

    initial begin
        int b0, n;
        reset = 1'b0;
        m_tready = 1'b0;
        err_clr = 1'b0;
        clr_force = 1'b0;
        clr_at = -1;
        rdy_pct = 100;
        gap_en = 1'b0;
        mon_en = 1'b0;
        beats_seen = 0;
        chk_main = 0; fail_main = 0; chk_mon = 0; fail_mon = 0;
        clear_bench();

        #12;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tid", 64'(m_tid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_err_trunc", 64'(err_trunc), 64'd0);

        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        cycle();

        // Single 3-beat packet from source 2.
        add_pkt(2, 3);
        issue();
        drain("t1", 100);
        chk("t1_err_trunc", 64'(err_trunc), 64'd0);

        // All sources contend with 2-beat packets; five packets in total.
        add_pkt(0, 2); add_pkt(0, 2);
        add_pkt(1, 2); add_pkt(2, 2); add_pkt(3, 2);
        issue();
        drain("t2", 200);

        // Backpressure during beat 2 of a source-1 packet.
        add_pkt(1, 3);
        issue();
        rdy_sched = '{1, 1, 0, 0, 0, 1, 1, 1};
        drain("t3", 100);

        // Over-length packet is split into a truncated segment and a remainder.
        add_pkt(0, 6);
        issue();
        drain("t4", 100);
        chk("t4_err_trunc", 64'(err_trunc), 64'(exp_trunc));

        // Clear alone, then a clear coinciding with a second truncation.
        pulse_clr();
        add_pkt(0, 12);
        issue();
        clr_at = 7;
        drain("t5", 200);
        clr_at = -1;
        chk("t5_set_beats_clr", 64'(err_trunc), 64'd1);
        pulse_clr();

        // Randomized traffic with gaps and backpressure.
        gap_en = 1'b1;
        rdy_pct = 70;
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < NS; s++) begin
                n = $urandom_range(2, 6);
                for (int p = 0; p < n; p++) add_pkt(s, $urandom_range(1, 7));
            end
            issue();
            drain("rand", 20000);
            chk("rand_err_trunc", 64'(err_trunc), 64'(exp_trunc));
            if (exp_trunc) pulse_clr();
        end
        gap_en = 1'b0;
        rdy_pct = 100;

        // Reset asserted in the middle of a source-3 packet.
        add_pkt(3, 4);
        issue();
        b0 = beats_seen;
        n = 0;
        while (beats_seen == b0 && n < 100) begin
            cycle();
            n++;
        end
        chk("t6_first_beat_seen", 64'(beats_seen > b0), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_async_s_tready", 64'(s_tready), 64'd0);
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_pkt_count", 64'(pkt_count), 64'd0);
        mon_en = 1'b0;
        clear_bench();
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        add_pkt(3, 1);
        add_pkt(0, 1);
        issue();
        chk("t6_model_first_is_src0", 64'(exp_q[0].id), 64'd0);
        drain("t6", 100);

        $display("TB_RESULT checks=%0d failures=%0d", chk_main + chk_mon, fail_main + fail_mon);
        $finish;
    end

endmodule
